// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle control unit and the datapath/memory.
// The controller is the master: it issues memory requests and datapath controls,
// and receives the opcode, ALU zero flag and memory acknowledge.
interface multicycle_ctrl_if #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
);
    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic              ir_write;
    logic              pc_inc;
    logic              pc_write;
    logic [ALUOPW-1:0] alu_op;
    logic [1:0]        alu_src_a;
    logic [1:0]        alu_src_b;
    logic [1:0]        reg_dst;
    logic [1:0]        mem_to_reg;
    logic              reg_write;
    logic              retire;
    logic [1:0]        trap;
    logic [2:0]        state;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_we, ir_write, pc_inc, pc_write, alu_op,
               alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
               retire, trap, state
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_we, ir_write, pc_inc, pc_write, alu_op,
               alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
               retire, trap, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the 16-bit core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, decodes the 4-bit ISA into datapath
// controls, waits on a req/ack memory handshake with an optional timeout,
// and traps (sticky until rst) on illegal opcodes or memory timeout.
module multicycle_ctrl #(
    parameter int OPW     = 4,
    parameter int ALUOPW  = 3,
    parameter int TIMEOUT = 0,
    parameter int TOW     = 8
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    // Moore control word; pc_jal/brz feed the EXEC-phase pc_write
    typedef struct packed {
        logic              mem_req;
        logic              mem_we;
        logic              pc_jal;
        logic              brz;
        logic [ALUOPW-1:0] alu_op;
        logic [1:0]        alu_src_a;
        logic [1:0]        alu_src_b;
        logic [1:0]        reg_dst;
        logic [1:0]        mem_to_reg;
        logic              reg_write;
        logic              retire;
    } ctl_t;

    localparam logic [OPW-1:0] OP_ADI = OPW'(8);
    localparam logic [OPW-1:0] OP_SWP = OPW'(9);
    localparam logic [OPW-1:0] OP_LDW = OPW'(10);
    localparam logic [OPW-1:0] OP_STW = OPW'(11);
    localparam logic [OPW-1:0] OP_BRZ = OPW'(12);
    localparam logic [OPW-1:0] OP_JAL = OPW'(13);
    localparam logic [OPW-1:0] OP_ILL = OPW'(14);

    state_t          st, st_n;
    logic [OPW-1:0]  op_q, op_n;
    logic [TOW-1:0]  cnt, cnt_n;
    logic [1:0]      trap_q, trap_n;
    ctl_t            ctl, ctl_n;
    logic            tmo_hit;

    // Control word that a given state presents for a given (latched) opcode
    function automatic ctl_t ctl_for(input state_t s, input logic [OPW-1:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: c.mem_req = 1'b1;
            S_EXEC, S_MEM: begin
                if (op < OP_ADI) begin
                    c.alu_op = ALUOPW'(op[2:0]);
                end else if (op == OP_ADI) begin
                    c.alu_src_b = 2'b01;
                end else if (op == OP_SWP) begin
                    c.alu_src_a = 2'b10;
                    c.alu_src_b = 2'b10;
                end else if (op == OP_LDW || op == OP_STW || op == OP_BRZ) begin
                    c.alu_src_b = 2'b11;
                end
                if (s == S_EXEC) begin
                    c.pc_jal = (op == OP_JAL);
                    c.brz    = (op == OP_BRZ);
                    c.retire = (op == OP_BRZ);
                end else begin
                    c.mem_req = 1'b1;
                    c.mem_we  = (op == OP_STW);
                end
            end
            S_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
                if (op == OP_JAL) begin
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b10;
                end else if (op == OP_LDW) begin
                    c.reg_dst    = 2'b00;
                    c.mem_to_reg = 2'b01;
                end else if (op == OP_ADI) begin
                    c.reg_dst    = 2'b00;
                end else begin
                    c.reg_dst    = 2'b01;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Limit reached on this wait cycle; an ack in the same cycle takes priority
    assign tmo_hit = (TIMEOUT != 0) && (cnt == TOW'(TIMEOUT - 1));

    // Next-state, opcode latch, timeout counter and sticky trap computation
    always_comb begin
        st_n   = st;
        op_n   = op_q;
        cnt_n  = cnt;
        trap_n = trap_q;
        case (st)
            S_IDLE: st_n = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ack) begin
                    st_n = S_DECODE;
                end else if (tmo_hit) begin
                    st_n   = S_TRAP;
                    trap_n = 2'b10;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DECODE: begin
                op_n = bus.opcode;
                if (bus.opcode >= OP_ILL) begin
                    st_n   = S_TRAP;
                    trap_n = 2'b01;
                end else begin
                    st_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_LDW || op_q == OP_STW) begin
                    st_n = S_MEM;
                end else if (op_q == OP_BRZ) begin
                    st_n = S_FETCH;
                end else begin
                    st_n = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    st_n = (op_q == OP_STW) ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    st_n   = S_TRAP;
                    trap_n = 2'b10;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WB:    st_n = S_FETCH;
            S_TRAP:  st_n = S_TRAP;
            default: st_n = S_IDLE;
        endcase
        if ((st_n == S_FETCH && st != S_FETCH) || (st_n == S_MEM && st != S_MEM)) begin
            cnt_n = '0;
        end
        // Moore outputs are registered by decoding the state being entered,
        // so they line up with the state register without a decode stage after it
        ctl_n = ctl_for(st_n, op_n);
    end

    // State register with synchronous, active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= S_IDLE;
            op_q   <= '0;
            cnt    <= '0;
            trap_q <= '0;
            ctl    <= '0;
        end else begin
            st     <= st_n;
            op_q   <= op_n;
            cnt    <= cnt_n;
            trap_q <= trap_n;
            ctl    <= ctl_n;
        end
    end

    assign bus.state      = st;
    assign bus.trap       = trap_q;
    assign bus.mem_req    = ctl.mem_req;
    assign bus.mem_we     = ctl.mem_we;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.reg_dst    = ctl.reg_dst;
    assign bus.mem_to_reg = ctl.mem_to_reg;
    assign bus.reg_write  = ctl.reg_write;
    // Ack-qualified (Mealy) outputs
    assign bus.ir_write   = (st == S_FETCH) && bus.mem_ack;
    assign bus.pc_inc     = (st == S_FETCH) && bus.mem_ack;
    assign bus.pc_write   = ctl.pc_jal | (ctl.brz & bus.zero);
    assign bus.retire     = ctl.retire | ((st == S_MEM) && (op_q == OP_STW) && bus.mem_ack);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (TIMEOUT=4): every cycle the full
// output vector is compared against a hand-computed expected vector.
module tb_multicycle_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multicycle_ctrl_if #(.OPW(4), .ALUOPW(3)) bus ();

    multicycle_ctrl #(.OPW(4), .ALUOPW(3), .TIMEOUT(4), .TOW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {state, trap, mem_req, mem_we, ir_write, pc_inc, pc_write,
    //        alu_op, src_a, src_b, reg_dst, mem_to_reg, reg_write, retire}
    function automatic logic [22:0] ev(input int st, input int tr, input int rq, input int we,
                                       input int irw, input int pci, input int pcw, input int aop,
                                       input int sa, input int sb, input int rd, input int m2r,
                                       input int rw, input int ret);
        return {3'(st), 2'(tr), 1'(rq), 1'(we), 1'(irw), 1'(pci), 1'(pcw), 3'(aop),
                2'(sa), 2'(sb), 2'(rd), 2'(m2r), 1'(rw), 1'(ret)};
    endfunction

    function automatic logic [22:0] outs();
        return {bus.state, bus.trap, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_inc,
                bus.pc_write, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.retire};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare outputs 1ns later
    task automatic run(input int r, input int a, input int z, input int op,
                       input logic [22:0] exp, input string tag);
        @(negedge clk);
        rst         = 1'(r);
        bus.mem_ack = 1'(a);
        bus.zero    = 1'(z);
        bus.opcode  = 4'(op);
        #1;
        check(tag, {9'b0, outs()}, {9'b0, exp});
    endtask

    logic [22:0] e_idle, e_fw, e_fa, e_dec, e_mem_ld, e_mem_st;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        bus.zero    = 1'b0;
        bus.opcode  = '0;
        e_idle   = ev(0,0, 0,0,0,0,0, 0, 0,0,0,0, 0,0);
        e_fw     = ev(1,0, 1,0,0,0,0, 0, 0,0,0,0, 0,0);
        e_fa     = ev(1,0, 1,0,1,1,0, 0, 0,0,0,0, 0,0);
        e_dec    = ev(2,0, 0,0,0,0,0, 0, 0,0,0,0, 0,0);
        e_mem_ld = ev(4,0, 1,0,0,0,0, 0, 0,3,0,0, 0,0);
        e_mem_st = ev(4,0, 1,1,0,0,0, 0, 0,3,0,0, 0,0);

        // reset and ALU op (opcode 5), immediate ack
        run(1,0,0,0,  e_idle, "reset");
        run(0,0,0,0,  e_idle, "idle");
        run(0,1,0,5,  e_fa, "alu_fetch");
        run(0,0,0,5,  e_dec, "alu_decode");
        run(0,0,0,15, ev(3,0, 0,0,0,0,0, 5, 0,0,0,0, 0,0), "alu_exec");
        run(0,0,0,0,  ev(5,0, 0,0,0,0,0, 0, 0,0,1,0, 1,1), "alu_wb");

        // LDW, fetch acked on 2nd cycle, data acked on 3rd MEM cycle
        run(0,0,0,0,  e_fw, "ldw_fwait");
        run(0,1,0,10, e_fa, "ldw_fetch");
        run(0,0,0,10, e_dec, "ldw_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,3,0,0, 0,0), "ldw_exec");
        run(0,0,0,0,  e_mem_ld, "ldw_mem1");
        run(0,0,0,0,  e_mem_ld, "ldw_mem2");
        run(0,1,0,0,  e_mem_ld, "ldw_mem3_ack");
        run(0,0,0,0,  ev(5,0, 0,0,0,0,0, 0, 0,0,0,1, 1,1), "ldw_wb");

        // STW: write strobe only in MEM, retire on the ack cycle
        run(0,1,0,11, e_fa, "stw_fetch");
        run(0,0,0,11, e_dec, "stw_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,3,0,0, 0,0), "stw_exec");
        run(0,0,0,0,  e_mem_st, "stw_mem_wait");
        run(0,1,0,0,  ev(4,0, 1,1,0,0,0, 0, 0,3,0,0, 0,1), "stw_mem_ack");

        // BRZ taken then not taken
        run(0,1,0,12, e_fa, "brz1_fetch");
        run(0,0,0,12, e_dec, "brz1_decode");
        run(0,0,1,0,  ev(3,0, 0,0,0,0,1, 0, 0,3,0,0, 0,1), "brz_taken");
        run(0,1,0,12, e_fa, "brz0_fetch");
        run(0,0,0,12, e_dec, "brz0_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,3,0,0, 0,1), "brz_not_taken");

        // JAL
        run(0,1,0,13, e_fa, "jal_fetch");
        run(0,0,0,13, e_dec, "jal_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,1, 0, 0,0,0,0, 0,0), "jal_exec");
        run(0,0,0,0,  ev(5,0, 0,0,0,0,0, 0, 0,0,2,2, 1,1), "jal_wb");

        // ADI and SWP
        run(0,1,0,8,  e_fa, "adi_fetch");
        run(0,0,0,8,  e_dec, "adi_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,1,0,0, 0,0), "adi_exec");
        run(0,0,0,0,  ev(5,0, 0,0,0,0,0, 0, 0,0,0,0, 1,1), "adi_wb");
        run(0,1,0,9,  e_fa, "swp_fetch");
        run(0,0,0,9,  e_dec, "swp_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 2,2,0,0, 0,0), "swp_exec");
        run(0,0,0,0,  ev(5,0, 0,0,0,0,0, 0, 0,0,1,0, 1,1), "swp_wb");

        // ack in the same cycle as the timeout limit wins
        run(0,0,0,0,  e_fw, "lim_wait1");
        run(0,0,0,0,  e_fw, "lim_wait2");
        run(0,0,0,0,  e_fw, "lim_wait3");
        run(0,1,0,0,  e_fa, "lim_ack4");
        run(0,0,0,0,  e_dec, "lim_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,0,0,0, 0,0), "lim_exec");
        run(0,0,0,0,  ev(5,0, 0,0,0,0,0, 0, 0,0,1,0, 1,1), "lim_wb");

        // fetch timeout after 4 wait cycles, held until rst
        for (int i = 0; i < 4; i++) run(0,0,0,0, e_fw, "tmo_fwait");
        run(0,0,0,0,  ev(7,2, 0,0,0,0,0, 0, 0,0,0,0, 0,0), "tmo_fetch_trap");
        run(1,0,0,0,  ev(7,2, 0,0,0,0,0, 0, 0,0,0,0, 0,0), "tmo_rst_cycle");
        run(0,0,0,0,  e_idle, "tmo_after_rst");

        // illegal opcode 0xE traps and stays there with inputs wiggling
        run(0,1,0,14, e_fa, "ill_fetch");
        run(0,0,0,14, e_dec, "ill_decode");
        for (int i = 0; i < 20; i++)
            run(0,1,i%2,i%16, ev(7,1, 0,0,0,0,0, 0, 0,0,0,0, 0,0), "ill_trap_stuck");

        // rst in the middle of a MEM wait
        run(1,0,0,0,  ev(7,1, 0,0,0,0,0, 0, 0,0,0,0, 0,0), "ill_rst_cycle");
        run(0,0,0,0,  e_idle, "ill_after_rst");
        run(0,1,0,10, e_fa, "rstm_fetch");
        run(0,0,0,10, e_dec, "rstm_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,3,0,0, 0,0), "rstm_exec");
        run(0,0,0,0,  e_mem_ld, "rstm_mem_wait");
        run(1,0,0,0,  e_mem_ld, "rstm_rst_cycle");
        run(0,1,0,0,  e_idle, "rstm_idle");

        // data-phase timeout on a store
        run(0,1,0,11, e_fa, "mtmo_fetch");
        run(0,0,0,11, e_dec, "mtmo_decode");
        run(0,0,0,0,  ev(3,0, 0,0,0,0,0, 0, 0,3,0,0, 0,0), "mtmo_exec");
        for (int i = 0; i < 4; i++) run(0,0,0,0, e_mem_st, "mtmo_mem_wait");
        run(0,0,0,0,  ev(7,2, 0,0,0,0,0, 0, 0,0,0,0, 0,0), "mtmo_trap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
